// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse period meter.
package pulse_meter_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/adder_n.sv
// N-bit ripple-carry adder built from per-bit full adders.
module adder_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    logic [N:0] w_carry;

    assign w_carry[0] = i_cin;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout = w_carry[N];

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the number of enabled clk cycles between successive pulse events and
// hands each result to a consumer through a valid/ready handshake.
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         pulse_in,
    input  logic         ready,
    output logic [N-1:0] period,
    output logic         period_sat,
    output logic         valid,
    output logic         overrun
);

    state_t       r_state;
    logic [N-1:0] r_count;
    logic [N-1:0] r_period;
    logic         r_period_sat;
    logic         r_valid;
    logic         r_overrun;

    state_t       w_state_next;
    logic [N-1:0] w_count_next;
    logic [N-1:0] w_period_next;
    logic         w_period_sat_next;
    logic         w_valid_next;
    logic         w_overrun_next;
    logic         w_new_result;

    logic         w_event;
    logic         w_accept;
    logic [N-1:0] w_inc;
    logic         w_inc_cout;
    logic [N-1:0] w_inc_sat;

    assign w_event  = ena & pulse_in;
    assign w_accept = r_valid & ready;

    adder_n #(.N(N)) u_inc (
        .i_a    (r_count),
        .i_b    ('0),
        .i_cin  (1'b1),
        .o_sum  (w_inc),
        .o_cout (w_inc_cout)
    );

    // Clamp at all-ones instead of wrapping; the same value feeds both the
    // counter and the result, so a saturated interval reports 2^N-1.
    assign w_inc_sat = w_inc_cout ? '1 : w_inc;

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_new_result = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_event) begin
                    w_state_next = S_MEASURE;
                    w_count_next = '0;
                end
            end
            S_MEASURE: begin
                if (w_event) begin
                    w_count_next = '0;
                    w_new_result = 1'b1;
                end else if (ena) begin
                    w_count_next = w_inc_sat;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    always_comb begin
        w_period_next     = r_period;
        w_period_sat_next = r_period_sat;
        w_valid_next      = r_valid;
        w_overrun_next    = r_overrun;
        if (w_new_result) begin
            w_period_next     = w_inc_sat;
            w_period_sat_next = &w_inc_sat;
            w_valid_next      = 1'b1;
            // An overwrite only counts as overrun when the old result was not taken.
            if (r_valid && !ready) begin
                w_overrun_next = 1'b1;
            end
        end else if (w_accept) begin
            w_valid_next   = 1'b0;
            w_overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_period     <= '0;
            r_period_sat <= 1'b0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_period     <= w_period_next;
            r_period_sat <= w_period_sat_next;
            r_valid      <= w_valid_next;
            r_overrun    <= w_overrun_next;
        end
    end

    assign period     = r_period;
    assign period_sat = r_period_sat;
    assign valid      = r_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed self-checking bench for pulse_period_meter (N=8).
module tb_pulse_period_meter;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       pulse_in;
    logic       ready;
    logic [7:0] period;
    logic       period_sat;
    logic       valid;
    logic       overrun;

    int n_pass;
    int n_total;

    pulse_period_meter #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .pulse_in   (pulse_in),
        .ready      (ready),
        .period     (period),
        .period_sat (period_sat),
        .valid      (valid),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-22s got=%0d", tag, got);
        end else begin
            $display("FAIL %-22s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Apply inputs, then advance to 1 time unit past the next rising edge.
    task automatic step(input logic p, input logic e, input logic r);
        pulse_in = p;
        ena      = e;
        ready    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, r);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b1;
        ena      = 1'b0;
        pulse_in = 1'b0;
        ready    = 1'b0;
        @(posedge clk);
        #1;
        check("rst_period", period, 0);
        check("rst_sat", period_sat, 0);
        check("rst_valid", valid, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;

        // Pulses every 5 cycles, 4 pulses, ready high.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b1);
            if (k == 0) begin
                check("p5_ref_valid", valid, 0);
            end else begin
                check("p5_valid", valid, 1);
                check("p5_period", period, 5);
                check("p5_sat", period_sat, 0);
            end
            step(1'b0, 1'b1, 1'b1);
            check("p5_valid_drop", valid, 0);
            if (k < 3) idle(3, 1'b1);
        end

        // Long interval saturates; exact 255 also flags; 254 does not.
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        idle(299, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("sat300_period", period, 255);
        check("sat300_sat", period_sat, 1);
        idle(254, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("exact255_period", period, 255);
        check("exact255_sat", period_sat, 1);
        idle(253, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("i254_period", period, 254);
        check("i254_sat", period_sat, 0);

        // pulse_in held high: reference then three period=1 results.
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        check("b2b_ref_valid", valid, 0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b1);
            check("b2b_valid", valid, 1);
            check("b2b_period", period, 1);
        end
        step(1'b0, 1'b1, 1'b1);
        check("b2b_valid_drop", valid, 0);

        // ready low, pulses every 3 cycles: overwrite sets overrun.
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("ov_first_valid", valid, 1);
        check("ov_first_overrun", overrun, 0);
        idle(2, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("ov_period", period, 3);
        check("ov_valid", valid, 1);
        check("ov_overrun", overrun, 1);
        step(1'b0, 1'b1, 1'b1);
        check("acc_valid", valid, 0);
        check("acc_overrun", overrun, 0);
        check("acc_period_hold", period, 3);

        // Accept coinciding with a new result: load, keep valid and overrun.
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        idle(1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("co_p2", period, 2);
        idle(2, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("co_p3_overrun", overrun, 1);
        idle(3, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("co_period", period, 4);
        check("co_valid", valid, 1);
        check("co_overrun_kept", overrun, 1);
        step(1'b0, 1'b1, 1'b1);
        check("co_acc_valid", valid, 0);
        check("co_acc_overrun", overrun, 0);

        // ena low mid-interval (one of them with pulse_in high) is excluded.
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("ena_period", period, 4);
        check("ena_valid", valid, 1);
        step(1'b0, 1'b0, 1'b1);
        check("ena_hs_valid", valid, 0);

        // Asynchronous reset mid-interval with live outputs.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("pre_rst_overrun", overrun, 1);
        idle(2, 1'b0);
        rst = 1'b1;
        #1;
        check("arst_period", period, 0);
        check("arst_valid", valid, 0);
        check("arst_overrun", overrun, 0);
        check("arst_sat", period_sat, 0);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        check("post_rst_ref", valid, 0);
        idle(5, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("post_rst_period", period, 6);
        check("post_rst_valid", valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 Parameter N, default 8: width of the period counter and of the result.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ena  input  1  count enable; cycles with ena=0 are ignored entirely (no count, no event).
REQ-005 pulse_in  input  1  event strobe; each cycle with pulse_in=1 and ena=1 is one event.
REQ-006 ready  input  1  consumer accepts the result when valid=1 and ready=1 in the same cycle.
REQ-007 period  output  N  last measured period, in enabled clk cycles.
REQ-008 period_sat  output  1  period saturated at 2^N-1; true interval unknown.
REQ-009 valid  output  1  period/period_sat hold an unconsumed result.
REQ-010 overrun  output  1  sticky: a result was overwritten before acceptance.

Function
REQ-011 FSM states SHALL be S_IDLE (no reference event yet) and S_MEASURE (counting since last event).
REQ-012 S_IDLE + event -> S_MEASURE, counter <= 0, no result produced.
REQ-013 S_MEASURE, enabled cycle without event -> counter <= counter+1, saturating at 2^N-1 (no wrap-around).
REQ-014 S_MEASURE + event -> result = counter+1 (saturating), counter <= 0, stay in S_MEASURE.
REQ-015 Pulses every T enabled cycles SHALL yield period=T for every interval after the first event; back-to-back events yield period=1.
REQ-016 period_sat SHALL be 1 when the result equals 2^N-1 because of saturation, including an exact interval of 2^N-1.
REQ-017 Result capture SHALL register period/period_sat and set valid one cycle after the completing event (latency 1).
REQ-018 Accept (valid&ready) with no new result that cycle -> valid <= 0; period holds its value.
REQ-019 Accept and new result in the same cycle -> new result is loaded, valid stays 1, overrun unchanged.
REQ-020 New result while valid=1 and ready=0 -> result overwritten, valid stays 1, overrun <= 1.
REQ-021 overrun SHALL clear on the cycle after an accept that does not coincide with another overwrite.
REQ-022 ena=0 SHALL freeze the counter and FSM; the output handshake (valid/ready) SHALL still operate.
REQ-023 Arithmetic is unsigned, N bits; the increment has no carry into period.

Reset
REQ-024 rst=1 SHALL asynchronously force S_IDLE, counter=0, period=0, period_sat=0, valid=0, overrun=0.
REQ-025 rst mid-measurement SHALL discard the partial interval; the first event after release is a reference only.

Structure
REQ-026 Package pulse_meter_pkg SHALL hold the state enum (S_IDLE, S_MEASURE) and the default width constant.
REQ-027 The increment SHALL use the existing adder_n ripple adder; no other sub-module is required.
REQ-028 Implementation SHALL use one always_ff for state/counter/output registers and always_comb for next-state logic.

Verification
REQ-029 N=8, ena=1, pulse_in every 5 cycles for 4 pulses, ready=1 -> three results period=5, period_sat=0, each valid for 1 cycle, 1 cycle after pulse.
REQ-030 Pulses at cycles 0 and 300, N=8 -> period=255, period_sat=1.
REQ-031 pulse_in held high 4 cycles, ready=1 -> first event is reference, then three results period=1.
REQ-032 ready=0, pulses every 3 cycles, 3 pulses -> period=3, valid=1, overrun=1; raise ready 1 cycle -> valid=0 next cycle, overrun=0.
REQ-033 Pulses every 4 cycles with ena low 2 cycles mid-interval -> period=4 (disabled cycles excluded).
REQ-034 rst asserted between cycles (asynchronous) mid-interval -> all outputs 0 immediately; next pulse gives no result; following pulse 6 cycles later -> period=6.
